// File: rtl/wb_pkg.sv
// Shared codes for the write-back sequencer and the register-bank write-data mux.
package wb_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    localparam logic [1:0] KIND_ALU  = 2'd0;
    localparam logic [1:0] KIND_LOAD = 2'd1;
    localparam logic [1:0] KIND_C227 = 2'd2;
    localparam logic [1:0] KIND_RSVD = 2'd3;

    localparam logic [3:0] SEL_WSRC = 4'b0000;
    localparam logic [3:0] SEL_MEM  = 4'b0001;
    localparam logic [3:0] SEL_C227 = 4'b0010;

    function automatic logic [3:0] kind_to_sel(input logic [1:0] kind);
        case (kind)
            KIND_LOAD: kind_to_sel = SEL_MEM;
            KIND_C227: kind_to_sel = SEL_C227;
            default:   kind_to_sel = SEL_WSRC;
        endcase
    endfunction

endpackage

// File: rtl/wb_sequencer_if.sv
// Request/result bundle between the main control FSM (master) and the write-back sequencer (slave).
interface wb_sequencer_if;
    logic       wb_req;
    logic [1:0] wb_kind;
    logic [4:0] wb_dest;
    logic       flush;
    logic [3:0] mux_sel;
    logic       reg_wr;
    logic [4:0] reg_dst;
    logic       busy;
    logic       done;
    logic       bad_kind;

    modport master (
        output wb_req, wb_kind, wb_dest, flush,
        input  mux_sel, reg_wr, reg_dst, busy, done, bad_kind
    );

    modport slave (
        input  wb_req, wb_kind, wb_dest, flush,
        output mux_sel, reg_wr, reg_dst, busy, done, bad_kind
    );
endinterface

// File: rtl/wb_sequencer.sv
// Register-bank write-back sequencer: SP init after reset, load latency insertion, flush handling.
//   state    | meaning
//   ST_INIT  | reset held or just released, SP init write not yet issued
//   ST_IDLE  | no write-back pending
//   ST_WAIT  | load accepted, counting memory latency
//   ST_WRITE | write cycle on the outputs (SP init when r_init_wr)
module wb_sequencer
    import wb_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int SP_REG  = 29,
    parameter int CNT_W   = 4
) (
    input  logic            clk,
    input  logic            reset,
    wb_sequencer_if.slave   bus
);

    state_t             r_state;
    logic               r_init_wr;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_mux_sel;
    logic               r_reg_wr;
    logic [4:0]         r_reg_dst;
    logic               r_busy;
    logic               r_done;
    logic               r_bad_kind;

    assign bus.mux_sel  = r_mux_sel;
    assign bus.reg_wr   = r_reg_wr;
    assign bus.reg_dst  = r_reg_dst;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.bad_kind = r_bad_kind;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_INIT;
            r_init_wr  <= 1'b0;
            r_cnt      <= '0;
            r_mux_sel  <= SEL_WSRC;
            r_reg_wr   <= 1'b0;
            r_reg_dst  <= '0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_bad_kind <= 1'b0;
        end else begin
            r_reg_wr   <= 1'b0;
            r_done     <= 1'b0;
            r_bad_kind <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    r_state   <= ST_WRITE;
                    r_init_wr <= 1'b1;
                    r_mux_sel <= SEL_C227;
                    r_reg_dst <= 5'(SP_REG);
                    r_reg_wr  <= 1'b1;
                    r_busy    <= 1'b1;
                end
                ST_WAIT: begin
                    if (bus.flush) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (r_cnt == '0) begin
                        r_state  <= ST_WRITE;
                        r_reg_wr <= (r_reg_dst != 5'd0);
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    // The SP init write cannot be flushed or overlapped by a new request.
                    if (r_state == ST_WRITE && r_init_wr) begin
                        r_state   <= ST_IDLE;
                        r_init_wr <= 1'b0;
                        r_busy    <= 1'b0;
                    end else if (bus.flush) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (bus.wb_req && bus.wb_kind == KIND_RSVD) begin
                        r_state    <= ST_IDLE;
                        r_bad_kind <= 1'b1;
                        r_busy     <= 1'b0;
                    end else if (bus.wb_req && bus.wb_kind == KIND_LOAD && MEM_LAT != 0) begin
                        r_state   <= ST_WAIT;
                        r_mux_sel <= SEL_MEM;
                        r_reg_dst <= bus.wb_dest;
                        r_cnt     <= CNT_W'(MEM_LAT - 1);
                        r_busy    <= 1'b1;
                    end else if (bus.wb_req) begin
                        r_state   <= ST_WRITE;
                        r_mux_sel <= kind_to_sel(bus.wb_kind);
                        r_reg_dst <= bus.wb_dest;
                        r_reg_wr  <= (bus.wb_dest != 5'd0);
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_sequencer.sv
// Directed and randomized checks of wb_sequencer against a cycle-numbered behavioural model.
module tb_wb_sequencer;

    localparam int MEM_LAT = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_sequencer_if bus();

    wb_sequencer #(.MEM_LAT(MEM_LAT), .SP_REG(29), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: write times tracked as absolute edge numbers rather than a state machine.
    int         n_edge;
    int         init_phase;
    int         load_due;
    logic [3:0] m_sel;
    logic       m_wr;
    logic [4:0] m_dst;
    logic       m_busy;
    logic       m_done;
    logic       m_bad;

    function automatic void model_reset();
        init_phase = 0;
        load_due   = -1;
        m_sel  = 4'b0000;
        m_wr   = 1'b0;
        m_dst  = 5'd0;
        m_busy = 1'b1;
        m_done = 1'b0;
        m_bad  = 1'b0;
    endfunction

    function automatic void model_edge();
        n_edge++;
        if (reset) begin
            model_reset();
            return;
        end
        m_wr   = 1'b0;
        m_done = 1'b0;
        m_bad  = 1'b0;
        if (init_phase == 0) begin
            m_sel = 4'b0010; m_dst = 5'd29; m_wr = 1'b1; m_busy = 1'b1;
            init_phase = 1;
        end else if (init_phase == 1) begin
            m_busy = 1'b0;
            init_phase = 2;
        end else if (load_due >= 0) begin
            if (bus.flush) begin
                load_due = -1; m_busy = 1'b0;
            end else if (n_edge == load_due) begin
                m_wr = (m_dst != 0); m_done = 1'b1; m_busy = 1'b0;
                load_due = -1;
            end
        end else if (bus.flush) begin
            m_busy = 1'b0;
        end else if (bus.wb_req) begin
            case (bus.wb_kind)
                2'd3: m_bad = 1'b1;
                2'd1: begin
                    m_sel = 4'b0001; m_dst = bus.wb_dest;
                    if (MEM_LAT == 0) begin
                        m_wr = (bus.wb_dest != 0); m_done = 1'b1;
                    end else begin
                        m_busy = 1'b1; load_due = n_edge + MEM_LAT;
                    end
                end
                default: begin
                    m_sel = (bus.wb_kind == 2'd2) ? 4'b0010 : 4'b0000;
                    m_dst = bus.wb_dest;
                    m_wr  = (bus.wb_dest != 0);
                    m_done = 1'b1;
                end
            endcase
        end
    endfunction

    function automatic logic [12:0] obs();
        return {bus.mux_sel, bus.reg_wr, bus.reg_dst, bus.busy, bus.done, bus.bad_kind};
    endfunction

    function automatic logic [12:0] expv();
        return {m_sel, m_wr, m_dst, m_busy, m_done, m_bad};
    endfunction

    task automatic drive(input logic req, input logic [1:0] kind, input logic [4:0] dest, input logic fl);
        bus.wb_req  = req;
        bus.wb_kind = kind;
        bus.wb_dest = dest;
        bus.flush   = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Vector layout: {mux_sel[4], reg_wr, reg_dst[5], busy, done, bad_kind}
    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 2'd0, 5'd0, 1'b0);
        #1;
        model_reset();
        checks++;
        if (obs() !== {4'b0000, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset_values: got %b expected %b", obs(), {4'b0000, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0});
        end
        tick();
        reset = 1'b0;
        drive(1'b1, 2'd0, 5'd3, 1'b1);
        tick();
        checks++;
        if (obs() !== {4'b0010, 1'b1, 5'd29, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL sp_init_e0: got %b expected %b", obs(), {4'b0010, 1'b1, 5'd29, 1'b1, 1'b0, 1'b0});
        end
        drive(1'b1, 2'd0, 5'd3, 1'b0);
        tick();
        checks++;
        if (obs() !== {4'b0010, 1'b0, 5'd29, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL sp_init_e1: got %b expected %b", obs(), {4'b0010, 1'b0, 5'd29, 1'b0, 1'b0, 1'b0});
        end
        drive(1'b0, 2'd0, 5'd0, 1'b0);
        tick();
    endtask

    task automatic test_alu_b2b();
        drive(1'b1, 2'd0, 5'd8, 1'b0);
        tick();
        checks++;
        if (obs() !== {4'b0000, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL alu_dest8: got %b expected %b", obs(), {4'b0000, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0});
        end
        drive(1'b1, 2'd0, 5'd9, 1'b0);
        tick();
        checks++;
        if (obs() !== {4'b0000, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL alu_b2b_dest9: got %b expected %b", obs(), {4'b0000, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0});
        end
        drive(1'b1, 2'd2, 5'd17, 1'b0);
        tick();
        checks++;
        if (obs() !== {4'b0010, 1'b1, 5'd17, 1'b0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL c227_dest17: got %b expected %b", obs(), {4'b0010, 1'b1, 5'd17, 1'b0, 1'b1, 1'b0});
        end
        drive(1'b0, 2'd0, 5'd0, 1'b0);
        tick();
        checks++;
        if (obs() !== {4'b0010, 1'b0, 5'd17, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL alu_back_idle: got %b expected %b", obs(), {4'b0010, 1'b0, 5'd17, 1'b0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_load();
        drive(1'b1, 2'd1, 5'd5, 1'b0);
        tick();
        checks++;
        if (obs() !== {4'b0001, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL load_wait_k0: got %b expected %b", obs(), {4'b0001, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0});
        end
        drive(1'b1, 2'd0, 5'd12, 1'b0);
        tick();
        checks++;
        if (obs() !== {4'b0001, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL load_wait_k1_ignore: got %b expected %b", obs(), {4'b0001, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0});
        end
        drive(1'b0, 2'd0, 5'd0, 1'b0);
        tick();
        checks++;
        if (obs() !== {4'b0001, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL load_write_k2: got %b expected %b", obs(), {4'b0001, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0});
        end
        tick();
        checks++;
        if (obs() !== {4'b0001, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL load_after: got %b expected %b", obs(), {4'b0001, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 2'd1, 5'd6, 1'b0);
        tick();
        drive(1'b0, 2'd0, 5'd0, 1'b1);
        tick();
        checks++;
        if (obs() !== {4'b0001, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL flush_wait: got %b expected %b", obs(), {4'b0001, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0});
        end
        drive(1'b0, 2'd0, 5'd0, 1'b0);
        tick();
        checks++;
        if (obs() !== {4'b0001, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL flush_no_late_write: got %b expected %b", obs(), {4'b0001, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0});
        end
        drive(1'b1, 2'd0, 5'd7, 1'b1);
        tick();
        checks++;
        if (obs() !== {4'b0001, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL flush_drops_req: got %b expected %b", obs(), {4'b0001, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0});
        end
        drive(1'b0, 2'd0, 5'd0, 1'b0);
    endtask

    task automatic test_dest0_bad_kind();
        drive(1'b1, 2'd0, 5'd0, 1'b0);
        tick();
        checks++;
        if (obs() !== {4'b0000, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL dest0_no_wr: got %b expected %b", obs(), {4'b0000, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0});
        end
        drive(1'b1, 2'd3, 5'd4, 1'b0);
        tick();
        checks++;
        if (obs() !== {4'b0000, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL bad_kind_pulse: got %b expected %b", obs(), {4'b0000, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1});
        end
        drive(1'b0, 2'd0, 5'd0, 1'b0);
        tick();
        checks++;
        if (obs() !== {4'b0000, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL bad_kind_clears: got %b expected %b", obs(), {4'b0000, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom % 2), 2'($urandom % 4), 5'($urandom % 32), ($urandom % 8) == 0);
            tick();
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL random_cycle_%0d: got %b expected %b", i, obs(), expv());
            end
        end
        drive(1'b0, 2'd0, 5'd0, 1'b1);
        tick();
        drive(1'b0, 2'd0, 5'd0, 1'b0);
    endtask

    task automatic test_async_reset();
        drive(1'b1, 2'd1, 5'd10, 1'b0);
        tick();
        checks++;
        if (obs() !== expv()) begin
            errors++; $display("FAIL async_pre_wait: got %b expected %b", obs(), expv());
        end
        drive(1'b0, 2'd0, 5'd0, 1'b0);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (obs() !== {4'b0000, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL async_reset_values: got %b expected %b", obs(), {4'b0000, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0});
        end
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (obs() !== {4'b0010, 1'b1, 5'd29, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL async_sp_init_e0: got %b expected %b", obs(), {4'b0010, 1'b1, 5'd29, 1'b1, 1'b0, 1'b0});
        end
        tick();
        checks++;
        if (obs() !== {4'b0010, 1'b0, 5'd29, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL async_sp_init_e1: got %b expected %b", obs(), {4'b0010, 1'b0, 5'd29, 1'b0, 1'b0, 1'b0});
        end
        tick();
        checks++;
        if (obs() !== {4'b0010, 1'b0, 5'd29, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL async_load_lost: got %b expected %b", obs(), {4'b0010, 1'b0, 5'd29, 1'b0, 1'b0, 1'b0});
        end
    endtask

    initial begin
        n_edge = 0;
        model_reset();
        test_reset();
        test_alu_b2b();
        test_load();
        test_flush();
        test_dest0_bad_kind();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_sequencer.md
Name: wb_sequencer

Overview:
- Write-back sequencer for the multicycle core's register-bank write port.
- Accepts one write-back request per instruction from the main control FSM.
- Drives the 4-bit write-data mux selector, the destination register and the write enable.
- Inserts memory-read latency for loads and performs the one-shot stack-pointer initialisation (constant 227 into $sp) after reset.

Parameters:
MEM_LAT, 2, cycles between load request acceptance and load data valid at the mux (0..15)
SP_REG, 29, register index written by post-reset SP init
CNT_W, 4, width of latency counter

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
wb_req  in  1  write-back request, sampled on rising clk
wb_kind  in  2  0=ALU/write_src result, 1=LOAD, 2=CONST227, 3=reserved
wb_dest  in  5  destination register index
flush  in  1  abort pending write-back (exception/branch squash)
mux_sel  out  4  selector to write-data mux: 0000 write_src, 0001 mem, 0010 const 227
reg_wr  out  1  register-bank write enable
reg_dst  out  5  register-bank write address
busy  out  1  1 = request at next edge will be ignored
done  out  1  one-cycle pulse coincident with the write cycle
bad_kind  out  1  one-cycle pulse: request with wb_kind=3 was rejected

Behaviour:
- All outputs are registered. States: INIT, IDLE, WAIT, WRITE.
- Reset (async, any time, including mid-WAIT):
  - state=INIT, mux_sel=0000, reg_wr=0, reg_dst=0, busy=1, done=0, bad_kind=0, counter=0.
  - The in-flight request is lost.
- INIT:
  - E0 = first rising edge with reset low.
  - After E0: state=WRITE, mux_sel=0010, reg_dst=SP_REG, reg_wr=1, done=0, busy=1.
  - After E1: state=IDLE, reg_wr=0, busy=0.
  - wb_req and flush are ignored at E0 and E1.
- Acceptance: wb_req is accepted at an edge when state is IDLE, or WRITE (not the INIT write); back-to-back requests are allowed.
- ALU (kind 0) or CONST227 (kind 2) accepted at edge Ek:
  - After Ek: state=WRITE, mux_sel=0000 or 0010 respectively, reg_dst=wb_dest, reg_wr=1, done=1, busy=0.
- LOAD (kind 1) accepted at Ek:
  - MEM_LAT=0: behaves as ALU with mux_sel=0001.
  - MEM_LAT>=1:
    - After Ek: state=WAIT, mux_sel=0001, reg_dst=wb_dest, counter=MEM_LAT-1, reg_wr=0, busy=1.
    - Each edge in WAIT with counter>0 decrements the counter.
    - The edge with counter==0 moves to WRITE: reg_wr=1, done=1, busy=0.
    - reg_wr is first high after Ek+MEM_LAT.
  - mux_sel and reg_dst stay stable throughout WAIT and WRITE.
- WRITE lasts one cycle. It exits to IDLE (reg_wr=0, done=0, mux_sel holds its last value) unless a new request is accepted at that edge.
- reg_dst==0: reg_wr is forced to 0 in the write cycle; done still pulses.
- wb_kind=3: not accepted. Next cycle bad_kind=1 for one cycle; state goes to or stays IDLE.
- flush=1 at an edge in IDLE/WAIT/WRITE:
  - state=IDLE, reg_wr=0, done=0, busy=0, counter cleared.
  - flush has priority over a simultaneous wb_req, which is dropped.
  - A WRITE-state write already on the outputs during that cycle has completed; flush only cancels later activity.
- wb_req while busy=1 (WAIT/INIT) is silently ignored; the upstream FSM must hold it off via busy.

Decomposition:
- Shared package wb_pkg holds:
  - kind codes: KIND_ALU=2'd0, KIND_LOAD=2'd1, KIND_C227=2'd2
  - mux codes: SEL_WSRC=4'b0000, SEL_MEM=4'b0001, SEL_C227=4'b0010
  - the state encoding
- The mux codes are shared with the write-data mux instance.
- No sub-module; the latency down-counter is inline.

Test Plan:
- Reset released, no requests -> after E0: reg_wr=1, mux_sel=0010, reg_dst=29 for exactly one cycle; after E1: busy=0, reg_wr=0.
- ALU req, dest=8, at E3 -> after E3: reg_wr=1, mux_sel=0000, reg_dst=8, done=1; after E4: idle. Second ALU req dest=9 at E4 -> written after E4 (back-to-back).
- LOAD dest=5, MEM_LAT=2, req at Ek:
  - After Ek and Ek+1: busy=1, mux_sel=0001, reg_wr=0.
  - After Ek+2: reg_wr=1, done=1.
  - ALU req at Ek+1 is ignored.
- LOAD in WAIT + flush at Ek+1 -> no reg_wr, busy=0 after Ek+1. Flush together with wb_req in IDLE -> request dropped.
- dest=0 ALU -> done=1, reg_wr=0. kind=3 -> bad_kind pulse, no write.
- Reset asserted asynchronously mid-WAIT -> outputs immediately at reset values; SP init sequence repeats after release.
